// File: rtl/cmd_phy_ctrl.sv
// cmd_phy_ctrl - CMD-line PHY sequencer for one SD command/response exchange.
//
// Shifts a command frame out MSB-first, releases the line, and waits for the
// response start bit, giving up after a timeout. It gates an external
// serial-to-parallel deserializer for exactly one response frame, then
// captures the assembled response and checks its framing bits.
//
// Ports
//   sd_clock      CMD-line clock, all logic on posedge
//   reset         synchronous, active-high
//   start         request, accepted only in IDLE
//   cmd_word      command frame, latched when start is accepted
//   resp_expected latched with start; 0 skips the response phase
//   cmd_line      sampled CMD pad level (idle high)
//   cmd_out       serial TX data
//   cmd_oe        pad output enable
//   rx_clr        one-cycle clear to the deserializer
//   rx_en         deserializer enable (combinational)
//   rx_parallel   deserializer parallel output
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
//   timeout       valid with done: no start bit seen
//   frame_err     valid with done: bad transmission or end bit
//   resp_data     captured response, held until next capture or reset
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_TX      | driving the command frame onto the pad
// S_WAIT    | line released, waiting for the response start bit
// S_RX      | deserializer enabled for the rest of the response frame
// S_CAPTURE | latch rx_parallel and check framing bits
// S_DONE    | one-cycle done pulse, flags valid

module cmd_phy_ctrl #(
    parameter int CMD_BITS  = 48,
    parameter int RESP_BITS = 48,
    parameter int NCR_MIN   = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CMD_BITS-1:0]  cmd_word,
    input  logic                 resp_expected,
    input  logic                 cmd_line,
    output logic                 cmd_out,
    output logic                 cmd_oe,
    output logic                 rx_clr,
    output logic                 rx_en,
    input  logic [RESP_BITS-1:0] rx_parallel,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic                 frame_err,
    output logic [RESP_BITS-1:0] resp_data
);

    localparam int LEN_A   = (CMD_BITS > RESP_BITS) ? CMD_BITS : RESP_BITS;
    localparam int MAX_LEN = (LEN_A > TIMEOUT) ? LEN_A : TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] TX_LOAD  = CNT_W'(CMD_BITS - 1);
    // The start bit is taken in S_WAIT, so RX covers only the remaining bits.
    localparam logic [CNT_W-1:0] RX_LOAD  = CNT_W'(RESP_BITS - 2);
    localparam logic [CNT_W-1:0] NCR_CNT  = CNT_W'(NCR_MIN);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX      = 3'd1,
        S_WAIT    = 3'd2,
        S_RX      = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state, next_state;

    logic [CNT_W-1:0]    cnt;
    logic [CMD_BITS-2:0] tx_shift;
    logic                resp_exp_q;
    logic                wait_open;
    logic                start_bit;

    logic cmd_oe_d, cmd_out_d, rx_clr_d, busy_d, done_d;

    // S_TX/S_RX: down-counter, leave at zero. S_WAIT: up-counting turnaround timer.
    assign wait_open = (cnt >= NCR_CNT);
    assign start_bit = wait_open && !cmd_line;

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_TX;
            S_TX:      if (cnt == '0) next_state = resp_exp_q ? S_WAIT : S_DONE;
            // A start bit in the final timer cycle takes priority over timeout.
            S_WAIT: begin
                if (start_bit) begin
                    next_state = S_RX;
                end else if (cnt == TMO_LAST) begin
                    next_state = S_DONE;
                end
            end
            S_RX:      if (cnt == '0) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rx_en     = ((state == S_WAIT) && start_bit) || (state == S_RX);
        cmd_oe_d  = (next_state == S_TX);
        cmd_out_d = 1'b1;
        if (next_state == S_TX) begin
            cmd_out_d = (state == S_IDLE) ? cmd_word[CMD_BITS-1] : tx_shift[CMD_BITS-2];
        end
        rx_clr_d  = (state == S_TX) && (next_state == S_WAIT);
        busy_d    = (next_state != S_IDLE);
        done_d    = (next_state == S_DONE);
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            cnt        <= '0;
            tx_shift   <= '0;
            resp_exp_q <= 1'b0;
            cmd_oe     <= 1'b0;
            cmd_out    <= 1'b1;
            rx_clr     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            frame_err  <= 1'b0;
            resp_data  <= '0;
        end else begin
            cmd_oe  <= cmd_oe_d;
            cmd_out <= cmd_out_d;
            rx_clr  <= rx_clr_d;
            busy    <= busy_d;
            done    <= done_d;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt        <= TX_LOAD;
                        tx_shift   <= cmd_word[CMD_BITS-2:0];
                        resp_exp_q <= resp_expected;
                        timeout    <= 1'b0;
                        frame_err  <= 1'b0;
                    end
                end
                S_TX: begin
                    tx_shift <= {tx_shift[CMD_BITS-3:0], 1'b0};
                    // Parks at zero so S_WAIT starts its timer from 0.
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_WAIT: begin
                    if (next_state == S_RX) begin
                        cnt <= RX_LOAD;
                    end else if (next_state == S_DONE) begin
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RX: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_CAPTURE: begin
                    resp_data <= rx_parallel;
                    frame_err <= rx_parallel[RESP_BITS-2] | ~rx_parallel[0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_phy_ctrl.sv
module tb_cmd_phy_ctrl;

    localparam int CMD_BITS  = 48;
    localparam int RESP_BITS = 48;
    localparam int NCR_MIN   = 2;
    localparam int TIMEOUT   = 64;
    localparam int NO_RESP   = 1000;

    logic                 sd_clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 start = 1'b0;
    logic [CMD_BITS-1:0]  cmd_word = '0;
    logic                 resp_expected = 1'b0;
    logic                 cmd_line = 1'b1;
    logic                 cmd_out, cmd_oe, rx_clr, rx_en;
    logic [RESP_BITS-1:0] rx_parallel = '0;
    logic                 busy, done, timeout, frame_err;
    logic [RESP_BITS-1:0] resp_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [RESP_BITS-1:0] exp_resp = '0;

    cmd_phy_ctrl #(
        .CMD_BITS(CMD_BITS), .RESP_BITS(RESP_BITS),
        .NCR_MIN(NCR_MIN), .TIMEOUT(TIMEOUT)
    ) dut (
        .sd_clock(sd_clock), .reset(reset), .start(start), .cmd_word(cmd_word),
        .resp_expected(resp_expected), .cmd_line(cmd_line), .cmd_out(cmd_out),
        .cmd_oe(cmd_oe), .rx_clr(rx_clr), .rx_en(rx_en), .rx_parallel(rx_parallel),
        .busy(busy), .done(done), .timeout(timeout), .frame_err(frame_err),
        .resp_data(resp_data)
    );

    always #5 sd_clock = ~sd_clock;

    // Simple deserializer the controller gates: MSB-first shift-in.
    always @(posedge sd_clock) begin
        if (rx_clr) rx_parallel <= '0;
        else if (rx_en) rx_parallel <= {rx_parallel[RESP_BITS-2:0], cmd_line};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CMD line level at turnaround index w (w=0 is the first cycle after TX).
    // glitch bit set = line pulled low during the ignored NCR window.
    function automatic logic line_at(input int w, input logic rexp, input int ws,
                                     input logic [RESP_BITS-1:0] resp,
                                     input logic [NCR_MIN-1:0] glitch);
        if (!rexp || w < 0) return 1'b1;
        if (w < NCR_MIN) return ~glitch[w];
        if (w < ws) return 1'b1;
        if (w < ws + RESP_BITS) return resp[RESP_BITS-1-(w-ws)];
        return 1'b1;
    endfunction

    // t counts cycles after the accepting edge; cycle t lies between edges k+t-1 and k+t.
    task automatic run_txn(input string name, input logic [CMD_BITS-1:0] word,
                           input logic rexp, input int ws, input logic [RESP_BITS-1:0] resp,
                           input logic [NCR_MIN-1:0] glitch, input int mid_start,
                           input int rst_t);
        int done_exp, ts, t_end;
        int oe_bad = 0, out_bad = 0, clr_bad = 0, rx_bad = 0, busy_bad = 0, done_bad = 0;
        logic got_resp, exp_tmo, exp_ferr, ab, e_oe, e_out, e_clr, e_rx, e_busy, e_done;

        got_resp = rexp && (ws < TIMEOUT);
        ts       = CMD_BITS + 1 + ws;
        if (!rexp)          done_exp = CMD_BITS + 1;
        else if (!got_resp) done_exp = CMD_BITS + TIMEOUT + 1;
        else                done_exp = ts + RESP_BITS + 1;
        exp_tmo  = rexp && !got_resp;
        exp_ferr = got_resp && ((resp[RESP_BITS-2] !== 1'b0) || (resp[0] !== 1'b1));
        t_end    = ((rst_t > 0) ? rst_t : done_exp) + 4;

        cmd_word      = word;
        resp_expected = rexp;
        cmd_line      = 1'b1;
        start         = 1'b1;
        @(posedge sd_clock); #1;

        for (int t = 1; t <= t_end; t++) begin
            start         = (t == mid_start);
            cmd_word      = CMD_BITS'({$urandom, $urandom});
            resp_expected = 1'($urandom_range(0, 1));
            reset         = (t == rst_t);
            cmd_line      = line_at(t - CMD_BITS - 1, rexp, ws, resp, glitch);
            @(negedge sd_clock);
            ab     = (rst_t > 0) && (t > rst_t);
            e_oe   = !ab && (t <= CMD_BITS);
            e_out  = e_oe ? word[CMD_BITS-t] : 1'b1;
            e_clr  = !ab && rexp && (t == CMD_BITS + 1);
            e_rx   = !ab && got_resp && (t >= ts) && (t < ts + RESP_BITS);
            e_busy = !ab && (t <= done_exp);
            e_done = !ab && (t == done_exp);
            if (cmd_oe !== e_oe)   oe_bad++;
            if (cmd_out !== e_out) out_bad++;
            if (rx_clr !== e_clr)  clr_bad++;
            if (rx_en !== e_rx)    rx_bad++;
            if (busy !== e_busy)   busy_bad++;
            if (done !== e_done)   done_bad++;
            if (rst_t == 0 && t == done_exp) begin
                chk({name, "/timeout"}, 64'(timeout), 64'(exp_tmo));
                chk({name, "/frame_err"}, 64'(frame_err), 64'(exp_ferr));
            end
            @(posedge sd_clock); #1;
        end
        reset = 1'b0;
        start = 1'b0;

        chk({name, "/cmd_oe_cycles_bad"}, 64'(oe_bad), 64'd0);
        chk({name, "/cmd_out_cycles_bad"}, 64'(out_bad), 64'd0);
        chk({name, "/rx_clr_cycles_bad"}, 64'(clr_bad), 64'd0);
        chk({name, "/rx_en_cycles_bad"}, 64'(rx_bad), 64'd0);
        chk({name, "/busy_cycles_bad"}, 64'(busy_bad), 64'd0);
        chk({name, "/done_cycles_bad"}, 64'(done_bad), 64'd0);
        if (rst_t > 0) begin
            exp_resp = '0;
            chk({name, "/timeout_after_reset"}, 64'(timeout), 64'd0);
            chk({name, "/frame_err_after_reset"}, 64'(frame_err), 64'd0);
        end else if (got_resp) begin
            exp_resp = resp;
        end
        chk({name, "/resp_data"}, 64'(resp_data), 64'(exp_resp));
    endtask

    initial begin
        logic [CMD_BITS-1:0]  w;
        logic [RESP_BITS-1:0] r;
        logic                 re;
        int                   ws, mid, rst;
        logic [NCR_MIN-1:0]   gl;

        reset = 1'b1;
        repeat (3) @(posedge sd_clock);
        #1;
        chk("reset/busy", 64'(busy), 64'd0);
        chk("reset/done", 64'(done), 64'd0);
        chk("reset/cmd_oe", 64'(cmd_oe), 64'd0);
        chk("reset/cmd_out", 64'(cmd_out), 64'd1);
        chk("reset/rx_clr", 64'(rx_clr), 64'd0);
        chk("reset/rx_en", 64'(rx_en), 64'd0);
        chk("reset/flags", 64'({timeout, frame_err}), 64'd0);
        chk("reset/resp_data", 64'(resp_data), 64'd0);
        reset = 1'b0;
        @(posedge sd_clock); #1;

        run_txn("no_resp", 48'h40_0000_0000_95, 1'b0, 0, '0, '0, 0, 0);
        run_txn("resp_ok", 48'h48_0000_01AA_87, 1'b1, 5, 48'h08_0000_01AA_87, '0, 0, 0);
        run_txn("timeout", 48'h77_0000_0000_01, 1'b1, NO_RESP, '0, '0, 0, 0);
        run_txn("early_low", 48'h51_2345_6789_AB, 1'b1, 6, 48'h3C_DEAD_BEEF_01, 2'b11, 0, 0);
        run_txn("bad_end_bit", 48'h4D_0001_0000_7F, 1'b1, 3, 48'h08_0000_01AA_86, '0, 10, 0);
        run_txn("ncr_edge", 48'h5A_5A5A_5A5A_5B, 1'b1, NCR_MIN, 48'h0F_0F0F_0F0F_0F, 2'b01, 0, 0);
        run_txn("last_cycle", 48'h6E_FFFF_0000_11, 1'b1, TIMEOUT - 1, 48'h12_3456_789A_BD, '0, 0, 0);
        run_txn("rst_mid_tx", 48'h40_AAAA_5555_01, 1'b1, 4, 48'h08_1111_2222_33, '0, 0, 20);
        run_txn("resp_again", 48'h48_0000_01AA_87, 1'b1, 7, 48'h08_0000_01AA_87, '0, 0, 0);
        run_txn("rst_mid_rx", 48'h41_BBBB_CCCC_DD, 1'b1, 4, 48'h29_8765_4321_0F,
                '0, 0, CMD_BITS + 1 + 4 + 10);

        for (int i = 0; i < 24; i++) begin
            w   = CMD_BITS'({$urandom, $urandom});
            re  = ($urandom_range(0, 3) != 0);
            ws  = int'($urandom_range(NCR_MIN, TIMEOUT + 8));
            if (ws >= TIMEOUT) ws = NO_RESP;
            r   = RESP_BITS'({$urandom, $urandom});
            r[RESP_BITS-1] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                r[RESP_BITS-2] = 1'b0;
                r[0]           = 1'b1;
            end
            gl  = NCR_MIN'($urandom_range(0, 3));
            mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, CMD_BITS - 1)) : 0;
            rst = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, CMD_BITS)) : 0;
            run_txn($sformatf("rand%0d", i), w, re, ws, r, gl, mid, rst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
